// File: rtl/mano_pkg.sv
// Shared definitions for the Mano-style sequencer core: opcode constants,
// T-state encoding and opcode field placement.
// Optional feature macro: MANO_ADD_EN (enables the ADD instruction).
package mano_pkg;

  // Opcode occupies the OP_W most-significant bits of an instruction word.
  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP = 3'b000;
  localparam logic [OP_W-1:0] OP_MOV = 3'b001;
  localparam logic [OP_W-1:0] OP_LDI = 3'b010;
  localparam logic [OP_W-1:0] OP_LDA = 3'b011;
  localparam logic [OP_W-1:0] OP_ADD = 3'b100;
  localparam logic [OP_W-1:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
    T4 = 3'd4, T5 = 3'd5, T6 = 3'd6, T7 = 3'd7
  } tstate_e;

  // Instructions that fetch a second word and continue past T3.
  function automatic logic op_has_operand(input logic [OP_W-1:0] op);
`ifdef MANO_ADD_EN
    return (op == OP_LDI) || (op == OP_LDA) || (op == OP_ADD);
`else
    return (op == OP_LDI) || (op == OP_LDA);
`endif
  endfunction

endpackage

// File: rtl/mano_time_decoder.sv
// Converts the encoded T-state into one-hot timing signals t0..t7.
module mano_time_decoder
  import mano_pkg::*;
(
  input  logic [2:0] t,
  output logic [7:0] t_onehot
);

  // One-hot decode of the current T-state
  always_comb begin
    t_onehot    = '0;
    t_onehot[t] = 1'b1;
  end

endmodule

// File: rtl/mano_seq_core.sv
// Mano-style T-state sequencer core: fetch/execute of NOP, MOV, LDI, LDA,
// HLT and (with MANO_ADD_EN defined) ADD over a small internal memory.
// Optional feature macro: MANO_ADD_EN.
module mano_seq_core
  import mano_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          step,
  input  logic          start,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  input  logic          r_we,
  input  logic [DW-1:0] r_data,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] ir_out,
  output logic [AW-1:0] pc_out,
  output logic [2:0]    t_state,
  output logic          halted,
  output logic          carry
);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] pc, mar;
  logic [DW-1:0] mbr, ir, a, r;
  tstate_e       t_q, t_d;
  logic          halted_q, halted_d;
  logic [7:0]    ts;
  logic [OP_W-1:0] op;
  logic          adv;

  logic mar_from_pc, mar_from_mbr, mbr_load, pc_inc, ir_load;
  logic a_from_r, a_from_mbr;
`ifdef MANO_ADD_EN
  logic a_add;
  logic carry_q;
`endif

  assign op  = ir[DW-1 -: OP_W];
  assign adv = step && !halted_q;

  mano_time_decoder u_tdec (
    .t        (t_q),
    .t_onehot (ts)
  );

  // State register: T-state and halt flag
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      t_q      <= T0;
      halted_q <= 1'b1;
    end else begin
      t_q      <= t_d;
      halted_q <= halted_d;
    end
  end

  // Next-state: halt/start handling and T-state sequencing per opcode
  always_comb begin
    t_d      = t_q;
    halted_d = halted_q;
    if (halted_q) begin
      t_d = T0;
      if (start) halted_d = 1'b0;
    end else if (step) begin
      unique case (t_q)
        T3: begin
          t_d = op_has_operand(op) ? T4 : T0;
          if (op == OP_HLT) halted_d = 1'b1;
        end
        T5:      t_d = (op == OP_LDI) ? T0 : T6;
        T7:      t_d = T0;
        default: t_d = tstate_e'(t_q + 3'd1);
      endcase
    end
  end

  // Output decode: datapath strobes for the step cycle leaving each T-state
  always_comb begin
    mar_from_pc  = 1'b0;
    mar_from_mbr = 1'b0;
    mbr_load     = 1'b0;
    pc_inc       = 1'b0;
    ir_load      = 1'b0;
    a_from_r     = 1'b0;
    a_from_mbr   = 1'b0;
`ifdef MANO_ADD_EN
    a_add        = 1'b0;
`endif
    if (adv) begin
      if (ts[0]) mar_from_pc = 1'b1;
      if (ts[1] || ts[4]) begin
        mbr_load = 1'b1;
        pc_inc   = 1'b1;
      end
      if (ts[2]) ir_load = 1'b1;
      if (ts[3]) begin
        a_from_r    = (op == OP_MOV);
        mar_from_pc = op_has_operand(op);
      end
      if (ts[5]) begin
        a_from_mbr   = (op == OP_LDI);
        mar_from_mbr = (op != OP_LDI);
      end
      if (ts[6]) mbr_load = 1'b1;
      if (ts[7]) begin
        a_from_mbr = (op == OP_LDA);
`ifdef MANO_ADD_EN
        a_add      = (op == OP_ADD);
`endif
      end
    end
  end

  // Datapath registers; R is writable on any cycle and MOV sees its old value
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc  <= '0;
      mar <= '0;
      mbr <= '0;
      ir  <= '0;
      a   <= '0;
      r   <= '0;
`ifdef MANO_ADD_EN
      carry_q <= 1'b0;
`endif
    end else begin
      if (mar_from_pc)       mar <= pc;
      else if (mar_from_mbr) mar <= mbr[AW-1:0];
      if (mbr_load) mbr <= mem[mar];
      if (pc_inc)   pc  <= pc + 1'b1;
      if (ir_load)  ir  <= mbr;
      if (a_from_r)        a <= r;
      else if (a_from_mbr) a <= mbr;
`ifdef MANO_ADD_EN
      else if (a_add)      {carry_q, a} <= {1'b0, a} + {1'b0, mbr};
`endif
      if (r_we) r <= r_data;
    end
  end

  // Program memory: loadable only while halted, never cleared by reset
  always_ff @(posedge clock) begin
    if (reset_n && load_we && halted_q) mem[load_addr] <= load_data;
  end

`ifdef MANO_ADD_EN
  assign carry = carry_q;
`else
  assign carry = 1'b0;
`endif

  assign a_out   = a;
  assign ir_out  = ir;
  assign pc_out  = pc;
  assign t_state = t_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_mano_seq_core.sv
// Self-checking bench for mano_seq_core: directed programs plus randomized
// traffic against an instruction-level reference model.
module tb_mano_seq_core;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
`ifdef MANO_ADD_EN
  localparam bit ADD_EN = 1'b1;
`else
  localparam bit ADD_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          step = 1'b0, start = 1'b0, load_we = 1'b0, r_we = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0, r_data = '0;
  logic [DW-1:0] a_out, ir_out;
  logic [AW-1:0] pc_out;
  logic [2:0]    t_state;
  logic          halted, carry;

  always #5 clock = ~clock;

  mano_seq_core #(.DW(DW), .AW(AW)) dut (
    .clock(clock), .reset_n(reset_n), .step(step), .start(start),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .r_we(r_we), .r_data(r_data), .a_out(a_out), .ir_out(ir_out),
    .pc_out(pc_out), .t_state(t_state), .halted(halted), .carry(carry)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Instruction-level reference model
  logic [DW-1:0] m_mem [2**AW];
  logic [DW-1:0] m_a = '0, m_r = '0, m_ir = '0, m_word = '0, m_opnd = '0;
  logic [AW-1:0] m_pc = '0;
  bit            m_carry = 1'b0, m_halted = 1'b1;
  int            m_tc = 0, m_len = 4;

  task automatic model_advance();
    logic [AW-1:0] nx;
    logic [2:0]    op;
    int            sum;
    if (m_tc == 0) begin
      nx     = m_pc + 1'b1;
      m_word = m_mem[m_pc];
      m_opnd = m_mem[nx];
      op     = m_word[DW-1 -: 3];
      case (op)
        3'b010:  m_len = 6;
        3'b011:  m_len = 8;
        3'b100:  m_len = ADD_EN ? 8 : 4;
        default: m_len = 4;
      endcase
    end
    m_tc++;
    if (m_tc == m_len) begin
      op = m_word[DW-1 -: 3];
      case (op)
        3'b001: m_a = m_r;
        3'b010: m_a = m_opnd;
        3'b011: m_a = m_mem[m_opnd[AW-1:0]];
        3'b100: if (ADD_EN) begin
          sum     = int'(m_a) + int'(m_mem[m_opnd[AW-1:0]]);
          m_a     = sum[DW-1:0];
          m_carry = (sum > 255);
        end
        3'b111: m_halted = 1'b1;
        default: ;
      endcase
      if (m_len > 4) m_pc = m_pc + 2'd2;
      else           m_pc = m_pc + 1'b1;
      m_ir = m_word;
      m_tc = 0;
    end
  endtask

  // One clock cycle: drive inputs, update the model, compare after the edge
  task automatic cyc(input bit st, input bit stt, input bit rwe, input logic [DW-1:0] rd,
                     input bit lwe, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                     input bit rst);
    step = st; start = stt; r_we = rwe; r_data = rd;
    load_we = lwe; load_addr = la; load_data = ld; reset_n = !rst;
    if (rst) begin
      m_pc = '0; m_a = '0; m_r = '0; m_ir = '0; m_carry = 1'b0;
      m_tc = 0; m_halted = 1'b1;
    end else begin
      if (m_halted) begin
        if (lwe) m_mem[la] = ld;
        if (stt) m_halted = 1'b0;
      end else if (st) begin
        model_advance();
      end
      if (rwe) m_r = rd;
    end
    @(posedge clock);
    #1;
    check("t_state", t_state, m_tc);
    check("halted", halted, m_halted);
    if (m_tc == 0) begin
      check("a", a_out, m_a);
      check("pc", pc_out, m_pc);
      check("ir", ir_out, m_ir);
      check("carry", carry, m_carry);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, '0, 0, '0, '0, 0);
  endtask
  task automatic load(input logic [AW-1:0] ad, input logic [DW-1:0] d);
    cyc(0, 0, 0, '0, 1, ad, d, 0);
  endtask
  task automatic go();
    cyc(0, 1, 0, '0, 0, '0, '0, 0);
  endtask
  task automatic rst();
    cyc(0, 0, 0, '0, 0, '0, '0, 1);
  endtask
  task automatic setr(input logic [DW-1:0] d);
    cyc(0, 0, 1, d, 0, '0, '0, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
    rst();
    rst();
    check("rst_a", a_out, 32'h0);
    check("rst_halted", halted, 32'h1);
    for (int i = 0; i < 2**AW; i++) load(i[AW-1:0], '0);

    // LDI then HLT
    rst();
    load(0, 8'h40); load(1, 8'h2A); load(2, 8'hE0);
    go();
    n = 0;
    while (!halted && n < 20) begin steps(1); n++; end
    check("ldi_halt", halted, 32'h1);
    check("ldi_a", a_out, 32'h2A);
    check("ldi_pc", pc_out, 32'h3);

    // MOV takes R
    rst();
    setr(8'h5C);
    load(0, 8'h20); load(1, 8'hE0);
    go();
    steps(4);
    check("mov_a", a_out, 32'h5C);
    check("mov_running", halted, 32'h0);
    steps(4);
    check("mov_halt", halted, 32'h1);

    // LDA indirect through operand
    rst();
    load(0, 8'h60); load(1, 8'h0F); load(15, 8'h99); load(2, 8'hE0);
    go();
    steps(8);
    check("lda_a", a_out, 32'h99);
    steps(4);
    check("lda_halt", halted, 32'h1);

    // ADD (or NOP when the feature is absent)
    rst();
    load(0, 8'h40); load(1, 8'hF0); load(2, 8'h80); load(3, 8'h05);
    load(4, 8'hE0); load(5, 8'h20);
    go();
    steps(6);
    check("add_pre_a", a_out, 32'hF0);
`ifdef MANO_ADD_EN
    steps(8);
    check("add_a", a_out, 32'h10);
    check("add_carry", carry, 32'h1);
    check("add_pc", pc_out, 32'h4);
`else
    steps(4);
    check("addnop_a", a_out, 32'hF0);
    check("addnop_carry", carry, 32'h0);
    check("addnop_pc", pc_out, 32'h3);
    steps(4);
    check("addnop_next_ir", ir_out, 32'h05);
`endif

    // Reset mid-LDA, with a dropped load while running
    rst();
    load(0, 8'h60); load(1, 8'h0F); load(15, 8'h99); load(2, 8'hE0);
    go();
    steps(5);
    check("midlda_t", t_state, 32'h5);
    cyc(0, 0, 0, '0, 1, 4'd15, 8'h11, 0);
    cyc(1, 1, 1, 8'h12, 1, 4'd15, 8'h22, 1);
    check("midrst_a", a_out, 32'h0);
    check("midrst_pc", pc_out, 32'h0);
    check("midrst_ir", ir_out, 32'h0);
    check("midrst_t", t_state, 32'h0);
    check("midrst_halted", halted, 32'h1);
    go();
    steps(8);
    check("mem_kept", a_out, 32'h99);

    // PC wrap from 15 to 0
    rst();
    setr(8'h33);
    load(0, 8'h20);
    for (int i = 1; i < 2**AW; i++) load(i[AW-1:0], 8'h00);
    go();
    steps(64);
    check("wrap_pc", pc_out, 32'h0);
    setr(8'h66);
    steps(4);
    check("wrap_a", a_out, 32'h66);
    check("wrap_pc1", pc_out, 32'h1);

    // Randomized traffic
    rst();
    for (int i = 0; i < 2**AW; i++) load(i[AW-1:0], DW'($urandom));
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 10) < 7, ($urandom % 20) == 0, ($urandom % 10) == 0, DW'($urandom),
          ($urandom % 10) == 0, AW'($urandom), DW'($urandom), ($urandom % 150) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
